serial_pattern_checker: RTL and testbench
=========================================

Name: serial_pattern_checker

Overview:
- Receive-side companion to our D flip-flop stimulus: samples a single-bit stream (typically a flip-flop Q output) and compares it bit-by-bit against an expected cyclic pattern.
- Counts mismatches, records the first error position and reports pass/fail at the end of a programmed run.
- Synthesizable. Used both on-chip as a self-check block and as a bench-side monitor.

Parameters:
- PATTERN_W, 8, width of the expected pattern register; the pattern repeats every PATTERN_W bits
- LEN_W, 8, width of the run-length field (max run = 2^LEN_W-1 bits)
- CNT_W, 8, width of the error counter (saturating)
- TIMEOUT, 64, idle cycles without din_valid before timeout (only with CHK_TIMEOUT_EN)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; loads pattern/length and begins a run
- pattern  in  PATTERN_W  expected bit pattern, checked MSB first; captured on start
- length  in  LEN_W  number of bits to check; captured on start
- din  in  1  serial data bit under test
- din_valid  in  1  din is sampled on a rising edge only when high
- busy  out  1  high in ARM or CHECK
- done  out  1  one-cycle pulse when a run completes
- pass  out  1  valid from done until next start: 1 = zero errors and no timeout
- err_count  out  CNT_W  mismatches in the current or last run; saturates at all-ones
- first_err_idx  out  LEN_W  bit index (0-based) of the first mismatch; all-ones if none
- timeout  out  1  set when the run aborted on timeout; always 0 without CHK_TIMEOUT_EN

Behaviour:
- One clock domain: clk. Reset is synchronous and active-high on reset.
- Reset values: busy=0, done=0, pass=0, err_count=0, first_err_idx=all-ones, timeout=0, state=IDLE. Internal pattern, length, pointer and bit index also clear.
- FSM states: IDLE, ARM, CHECK, DONE.
- IDLE, start=1:
  - Capture pattern and length; clear err_count, first_err_idx, timeout and pass.
  - pattern pointer ptr := PATTERN_W-1; bit index idx := 0.
  - If length==0, go to DONE: done pulses on the next edge with pass=1.
  - Otherwise go to ARM.
- ARM: one cycle settling state; always goes to CHECK. din is ignored in ARM.
- CHECK, din_valid=1:
  - Compare din with pattern[ptr].
  - On mismatch: err_count += 1 (saturating). If this is the first error, first_err_idx := idx.
  - ptr decrements and wraps from 0 to PATTERN_W-1. idx increments.
  - When idx==length-1 is consumed, go to DONE.
- CHECK, din_valid=0: hold all state.
- Entering DONE: done=1 for exactly one cycle. pass := (err_count_final==0) && !timeout. Results hold until the next start.
- DONE, start=1: same as from IDLE; DONE behaves as IDLE for start.
- start asserted in ARM or CHECK: the current run aborts without a done pulse. Reload and restart as from IDLE, same cycle.
- Latency: the last valid bit sampled at edge N gives done=1 and final results visible after edge N+1.
- Mismatch on the final bit is counted before pass is evaluated.
- Reset mid-run: next edge returns to IDLE with reset values; no done pulse.
- Saturation: err_count stops at 2^CNT_W-1; pass is still 0.

Optional Feature:
- Macro: CHK_TIMEOUT_EN.
- Defined:
  - Idle counter runs in CHECK and clears on each din_valid.
  - When it reaches TIMEOUT, set timeout=1 and go to DONE; done pulses, pass=0.
  - Counts are frozen at their values at timeout.
- Undefined:
  - No counter is built and timeout is tied 0.
  - CHECK waits indefinitely for din_valid.

Test Plan:
- Pattern 8'b1010_0110, length 16, din matches every cycle with din_valid=1 -> done after 16 valid bits + 1 cycle; pass=1, err_count=0, first_err_idx=8'hFF.
- Same pattern, length 16, din inverted at idx 3 and idx 11 -> err_count=2, first_err_idx=3, pass=0.
- length 0 with start -> done pulse on the second edge after start; pass=1, err_count=0, busy never high.
- Pattern 8'hF0, length 12, din_valid toggling 1/0 every cycle -> only valid cycles are counted; wrap verified (idx 8..11 expect 1,1,1,1); done after the 12th valid bit.
- Run active at idx 5, start pulsed again with length 4 -> no done for the first run; second run completes after 4 valid bits. Separately, reset at idx 5 -> IDLE, err_count=0, no done.
- With CHK_TIMEOUT_EN, TIMEOUT=64: stop din_valid after 3 bits of a 10-bit run -> 64 cycles later timeout=1, done pulse, pass=0, err_count frozen.

Source files
------------

// File: rtl/serial_pattern_checker.sv
// Serial bit-stream checker: compares din against a cyclic expected pattern (MSB first),
// counts mismatches and reports pass/fail. Optional idle timeout via `define CHK_TIMEOUT_EN.
module serial_pattern_checker #(
  parameter int PATTERN_W = 8,
  parameter int LEN_W     = 8,
  parameter int CNT_W     = 8,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PATTERN_W-1:0] pattern,
  input  logic [LEN_W-1:0]     length,
  input  logic                 din,
  input  logic                 din_valid,
  output logic                 busy,
  output logic                 done,
  output logic                 pass,
  output logic [CNT_W-1:0]     err_count,
  output logic [LEN_W-1:0]     first_err_idx,
  output logic                 timeout
);

  localparam int PTR_W = (PATTERN_W > 1) ? $clog2(PATTERN_W) : 1;

  typedef enum logic [1:0] {IDLE, ARM, CHECK, DONE} state_t;

  state_t               state, state_nxt;
  logic [PATTERN_W-1:0] pat_q;
  logic [LEN_W-1:0]     len_q;
  logic [LEN_W-1:0]     idx;
  logic [PTR_W-1:0]     ptr;
  logic                 done_sent;
  logic                 mismatch;
  logic                 last_bit;
  logic                 sample;
  logic                 timeout_hit;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  assign sample   = (state == CHECK) && din_valid;
  assign mismatch = (din != pat_q[ptr]);
  assign last_bit = (idx == len_q - 1'b1);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // start wins in every state: from ARM/CHECK it silently abandons the run in progress
  always_comb begin
    state_nxt = state;
    if (start) begin
      state_nxt = (length == '0) ? DONE : ARM;
    end else begin
      case (state)
        ARM:     state_nxt = CHECK;
        CHECK:   if ((sample && last_bit) || timeout_hit) state_nxt = DONE;
        default: state_nxt = state;
      endcase
    end
  end

  always_comb begin
    busy = (state == ARM) || (state == CHECK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pat_q         <= '0;
      len_q         <= '0;
      idx           <= '0;
      ptr           <= '0;
      err_count     <= '0;
      first_err_idx <= '1;
      pass          <= 1'b0;
      done          <= 1'b0;
      done_sent     <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        pat_q         <= pattern;
        len_q         <= length;
        idx           <= '0;
        ptr           <= PTR_W'(PATTERN_W - 1);
        err_count     <= '0;
        first_err_idx <= '1;
        pass          <= 1'b0;
        done_sent     <= 1'b0;
      end else begin
        if (sample) begin
          if (mismatch) begin
            err_count <= sat_inc(err_count);
            if (err_count == '0) first_err_idx <= idx;
          end
          ptr <= (ptr == '0) ? PTR_W'(PATTERN_W - 1) : ptr - 1'b1;
          idx <= idx + 1'b1;
        end
        // First cycle in DONE: the final bit's mismatch is already in err_count
        if (state == DONE && !done_sent) begin
          done      <= 1'b1;
          done_sent <= 1'b1;
          pass      <= (err_count == '0) && !timeout;
        end
      end
    end
  end

`ifdef CHK_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT + 1);

  logic [TO_W-1:0] idle_cnt;
  logic            timeout_q;

  always_ff @(posedge clk) begin
    if (reset || start)   idle_cnt <= '0;
    else if (state == CHECK) idle_cnt <= din_valid ? '0 : idle_cnt + 1'b1;
  end

  // Fires on the TIMEOUT-th consecutive idle CHECK cycle
  assign timeout_hit = (state == CHECK) && !din_valid && (idle_cnt == TO_W'(TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (reset || start)   timeout_q <= 1'b0;
    else if (timeout_hit) timeout_q <= 1'b1;
  end

  assign timeout = timeout_q;
`else
  logic unused_timeout_cfg;

  assign unused_timeout_cfg = (TIMEOUT != 0);
  assign timeout_hit        = 1'b0;
  assign timeout            = 1'b0;
`endif

endmodule

// File: tb/tb_serial_pattern_checker.sv
// Directed bench for serial_pattern_checker: a run-level reference model is compared
// against the DUT every cycle, plus hand-computed expectations per scenario.
module tb_serial_pattern_checker;

  localparam int PW = 8;
  localparam int LW = 8;
  localparam int CW = 8;
  localparam int TO = 64;

  logic          clk = 1'b0;
  logic          reset, start, din, din_valid;
  logic [PW-1:0] pattern;
  logic [LW-1:0] length;
  logic          busy, done, pass, timeout;
  logic [CW-1:0] err_count;
  logic [LW-1:0] first_err_idx;

  int n_checks = 0;
  int n_fail   = 0;

  serial_pattern_checker #(.PATTERN_W(PW), .LEN_W(LW), .CNT_W(CW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .start(start), .pattern(pattern), .length(length),
    .din(din), .din_valid(din_valid), .busy(busy), .done(done), .pass(pass),
    .err_count(err_count), .first_err_idx(first_err_idx), .timeout(timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: a run is a count of consumed valid bits after a one-edge settle.
  logic          m_active, m_arm, m_pending, m_done, m_pass, m_timeout;
  logic [PW-1:0] m_pat;
  int            m_len, m_n, m_errs, m_first, m_idle;

  always @(posedge clk) begin
    m_done = 1'b0;
    if (reset) begin
      m_active = 0; m_arm = 0; m_pending = 0; m_pass = 0; m_timeout = 0;
      m_pat = '0; m_len = 0; m_n = 0; m_errs = 0; m_first = 255; m_idle = 0;
    end else if (start) begin
      m_pat = pattern; m_len = length; m_n = 0; m_errs = 0; m_first = 255;
      m_pass = 0; m_timeout = 0; m_idle = 0; m_arm = 1;
      m_active  = (length != 0);
      m_pending = (length == 0);
    end else begin
      if (m_pending) begin
        m_done = 1'b1;
        m_pass = (m_errs == 0) && !m_timeout;
        m_pending = 0;
      end
      if (m_active) begin
        if (m_arm) begin
          m_arm = 0;
        end else if (din_valid) begin
          m_idle = 0;
          if (din != m_pat[PW-1-(m_n % PW)]) begin
            if (m_errs == 0) m_first = m_n;
            m_errs++;
          end
          m_n++;
          if (m_n == m_len) begin m_active = 0; m_pending = 1; end
        end else begin
`ifdef CHK_TIMEOUT_EN
          m_idle++;
          if (m_idle == TO) begin m_timeout = 1; m_active = 0; m_pending = 1; end
`endif
        end
      end
    end
  end

  always @(negedge clk) begin
    check("busy",          busy,          m_active);
    check("done",          done,          m_done);
    check("pass",          pass,          m_pass);
    check("err_count",     err_count,     (m_errs > 255) ? 255 : m_errs);
    check("first_err_idx", first_err_idx, m_first);
    check("timeout",       timeout,       m_timeout);
  end

  task automatic start_run(input logic [PW-1:0] p, input logic [LW-1:0] n);
    @(negedge clk);
    start = 1'b1; pattern = p; length = n; din_valid = 1'b0;
    @(negedge clk);
    // Settle edge: drive a deliberately wrong valid bit that must be ignored
    start = 1'b0; din_valid = 1'b1; din = ~p[PW-1];
  endtask

  task automatic send_bits(input logic [PW-1:0] p, input int n, input int fa, input int fb,
                           input bit inv_all, input bit toggle);
    logic b;
    for (int i = 0; i < n; i++) begin
      b = p[PW-1-(i % PW)];
      if (toggle) begin
        @(negedge clk);
        din_valid = 1'b0; din = ~b;
      end
      @(negedge clk);
      din_valid = 1'b1;
      din = b ^ ((i == fa) || (i == fb) || inv_all);
    end
    @(negedge clk);
    din_valid = 1'b0;
  endtask

  task automatic wait_done(input int max, output int c);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!done && c < max);
    check("done_seen", done, 1'b1);
  endtask

  int c;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; start = 1'b0; din = 1'b0; din_valid = 1'b0; pattern = '0; length = '0;
    @(negedge clk);
    check("rst_busy", busy, 0);
    check("rst_err", err_count, 0);
    check("rst_first", first_err_idx, 8'hFF);
    check("rst_done", done, 0);
    check("rst_pass", pass, 0);
    @(negedge clk);
    reset = 1'b0;

    // Clean 16-bit run
    start_run(8'b1010_0110, 16);
    send_bits(8'b1010_0110, 16, -1, -1, 0, 0);
    wait_done(40, c);
    check("t1_latency", c, 1);
    check("t1_pass", pass, 1);
    check("t1_err", err_count, 0);
    check("t1_first", first_err_idx, 8'hFF);
    @(negedge clk);
    check("t1_done_one_cycle", done, 0);
    check("t1_pass_hold", pass, 1);

    // Two errors at idx 3 and 11
    start_run(8'b1010_0110, 16);
    send_bits(8'b1010_0110, 16, 3, 11, 0, 0);
    wait_done(40, c);
    check("t2_latency", c, 1);
    check("t2_err", err_count, 2);
    check("t2_first", first_err_idx, 3);
    check("t2_pass", pass, 0);

    // Zero-length run
    start_run(8'h00, 0);
    check("t3_busy", busy, 0);
    wait_done(10, c);
    check("t3_latency", c, 1);
    check("t3_pass", pass, 1);
    check("t3_err", err_count, 0);

    // Gapped valid, clean, then with an error in the wrapped region
    start_run(8'hF0, 12);
    send_bits(8'hF0, 12, -1, -1, 0, 1);
    wait_done(60, c);
    check("t4_latency", c, 1);
    check("t4_pass", pass, 1);
    start_run(8'hF0, 12);
    send_bits(8'hF0, 12, 9, -1, 0, 1);
    wait_done(60, c);
    check("t4b_err", err_count, 1);
    check("t4b_first", first_err_idx, 9);

    // Restart mid-run: first run (with an error) never reports
    start_run(8'b1010_0110, 16);
    send_bits(8'b1010_0110, 5, 2, -1, 0, 0);
    start_run(8'h3C, 4);
    send_bits(8'h3C, 4, -1, -1, 0, 0);
    wait_done(20, c);
    check("t5_latency", c, 1);
    check("t5_err", err_count, 0);
    check("t5_first", first_err_idx, 8'hFF);
    check("t5_pass", pass, 1);

    // Reset mid-run
    start_run(8'b1010_0110, 16);
    send_bits(8'b1010_0110, 5, 1, -1, 0, 0);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("t6_busy", busy, 0);
    check("t6_err", err_count, 0);
    check("t6_first", first_err_idx, 8'hFF);
    check("t6_done", done, 0);
    repeat (3) @(negedge clk);

    // Every bit wrong over the longest run: counter lands on all-ones
    start_run(8'h5A, 255);
    send_bits(8'h5A, 255, -1, -1, 1, 0);
    wait_done(20, c);
    check("t7_err", err_count, 255);
    check("t7_first", first_err_idx, 0);
    check("t7_pass", pass, 0);

`ifdef CHK_TIMEOUT_EN
    start_run(8'b1010_0110, 10);
    send_bits(8'b1010_0110, 3, -1, -1, 0, 0);
    wait_done(200, c);
    check("t8_latency", c, TO + 1);
    check("t8_timeout", timeout, 1);
    check("t8_pass", pass, 0);
    check("t8_err", err_count, 0);
`endif

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
